// File: rtl/spim_shifter.sv
// spim_shifter: SPI master data path. Sits after the SCLK/slave-select
// generator, drives MOSI from a single-entry transmit holding register and
// assembles MISO into a receive word. Handles all four CPOL/CPHA modes and
// MSB- or LSB-first ordering. SCLK is sampled as data in the system clock
// domain; its edges are found by comparing against a registered copy.
module spim_shifter #(
  parameter int DATA_SIZE = 16
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst_n,
  input  logic [DATA_SIZE-1:0] i_tx_data,
  input  logic                 i_tx_load,
  input  logic                 i_lsb_first,
  input  logic                 i_cpol,
  input  logic                 i_cpha,
  input  logic                 i_sclk,
  input  logic                 i_ss_n,
  input  logic                 i_miso,
  output logic                 o_mosi,
  output logic                 o_tx_ready,
  output logic [DATA_SIZE-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_tx_underrun,
  output logic                 o_rx_abort,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(DATA_SIZE + 1);

  // One-hot frame state.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_XFER = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  state_t r_state;

  // Edge-detect history and frame arming.
  logic r_sclk_d;
  logic r_ss_d;
  logic r_ss_seen;

  // Transmit side.
  logic [DATA_SIZE-1:0] r_hold;
  logic                 r_tx_ready;
  logic [DATA_SIZE-1:0] r_tx_shift;
  logic                 r_mosi;
  logic                 r_skip_shift;

  // Receive side.
  logic [DATA_SIZE-1:0] r_rx_shift;
  logic [DATA_SIZE-1:0] r_rx_data;
  logic [CNT_W-1:0]     r_bit_cnt;

  // Single-cycle status pulses.
  logic r_rx_valid;
  logic r_tx_underrun;
  logic r_rx_abort;

  // Combinational edge / frame conditions for the current cycle.
  logic w_lead;
  logic w_trail;
  logic w_sample;
  logic w_shift;
  logic w_start;
  logic w_end;

  // Data-path next values.
  logic [DATA_SIZE-1:0] w_start_word;
  logic [DATA_SIZE-1:0] w_tx_adv;
  logic [DATA_SIZE-1:0] w_rx_next;
  logic                 w_start_bit;
  logic                 w_adv_bit;
  logic                 w_last_sample;
  logic                 w_underrun;

  // SCLK leaves its idle level on a leading edge and returns on a trailing edge.
  assign w_lead  = (i_sclk != i_cpol) && (r_sclk_d == i_cpol);
  assign w_trail = (i_sclk == i_cpol) && (r_sclk_d != i_cpol);

  // CPHA picks which edge type samples; the other one shifts.
  assign w_sample = i_cpha ? w_trail : w_lead;
  assign w_shift  = i_cpha ? w_lead  : w_trail;

  // A start only counts once slave select has been seen high since reset, so
  // a frame interrupted by reset is ignored until its end.
  assign w_start = r_ss_d && !i_ss_n && r_ss_seen;
  assign w_end   = !r_ss_d && i_ss_n;

  // Word loaded at start: the held word if present, otherwise a word being
  // loaded in the same cycle, otherwise zeros (an underrun).
  assign w_underrun   = r_tx_ready && !i_tx_load;
  assign w_start_word = !r_tx_ready ? r_hold :
                        (i_tx_load ? i_tx_data : '0);

  // The current TX bit sits at the MSB (MSB first) or LSB (LSB first).
  assign w_tx_adv    = i_lsb_first ? (r_tx_shift >> 1) : (r_tx_shift << 1);
  assign w_start_bit = i_lsb_first ? w_start_word[0] : w_start_word[DATA_SIZE-1];
  assign w_adv_bit   = i_lsb_first ? w_tx_adv[0]     : w_tx_adv[DATA_SIZE-1];

  // LSB first shifts in at the top and moves right; MSB first the reverse.
  assign w_rx_next = i_lsb_first ? {i_miso, r_rx_shift[DATA_SIZE-1:1]}
                                 : {r_rx_shift[DATA_SIZE-2:0], i_miso};

  assign w_last_sample = (r_bit_cnt == CNT_W'(DATA_SIZE - 1));

  // Register SCLK and slave select for edge detection; remember a high SS.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_sclk_d  <= 1'b1;
      r_ss_d    <= 1'b1;
      r_ss_seen <= 1'b0;
    end else begin
      r_sclk_d  <= i_sclk;
      r_ss_d    <= i_ss_n;
      r_ss_seen <= r_ss_seen | i_ss_n;
    end
  end

  // Single-entry holding register: filled by an accepted load, emptied at start.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_hold     <= '0;
      r_tx_ready <= 1'b1;
    end else if ((r_state == ST_IDLE) && w_start) begin
      r_tx_ready <= 1'b1;
    end else if (i_tx_load && r_tx_ready) begin
      r_hold     <= i_tx_data;
      r_tx_ready <= 1'b0;
    end
  end

  // Frame FSM with the TX/RX shift registers, bit counter and status pulses.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_tx_shift    <= '0;
      r_mosi        <= 1'b0;
      r_skip_shift  <= 1'b0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_bit_cnt     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_rx_abort    <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_rx_abort    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mosi <= 1'b0;
          if (w_start) begin
            r_state       <= ST_XFER;
            r_tx_shift    <= w_start_word;
            r_mosi        <= w_start_bit;
            r_bit_cnt     <= '0;
            // With CPHA=1 bit 0 is already on the line, so the first
            // leading edge must not advance it.
            r_skip_shift  <= i_cpha;
            r_tx_underrun <= w_underrun;
          end
        end
        ST_XFER: begin
          if (w_end) begin
            r_state    <= ST_IDLE;
            r_mosi     <= 1'b0;
            r_rx_abort <= 1'b1;
          end else begin
            if (w_shift) begin
              if (r_skip_shift) begin
                r_skip_shift <= 1'b0;
              end else begin
                r_tx_shift <= w_tx_adv;
                r_mosi     <= w_adv_bit;
              end
            end
            if (w_sample) begin
              r_rx_shift <= w_rx_next;
              r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
              if (w_last_sample) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
                r_state    <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          // Further SCLK edges are ignored; MOSI holds until the frame ends.
          if (w_end) begin
            r_state <= ST_IDLE;
            r_mosi  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_mosi  <= 1'b0;
        end
      endcase
    end
  end

  assign o_mosi        = r_mosi;
  assign o_tx_ready    = r_tx_ready;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_underrun = r_tx_underrun;
  assign o_rx_abort    = r_rx_abort;
  assign o_busy        = (r_state == ST_XFER) || (r_state == ST_DONE);

endmodule

// File: tb/tb_spim_shifter.sv
// Testbench for spim_shifter: drives SCLK/SS like the generator (period 8
// system clocks), keeps a frame-level model of the expected outputs and
// compares every cycle, plus literal checks on the directed scenarios.
module tb_spim_shifter;

  logic        i_sys_clk = 1'b0;
  logic        i_sys_rst_n = 1'b0;
  logic [15:0] i_tx_data = '0;
  logic        i_tx_load = 1'b0;
  logic        i_lsb_first = 1'b0;
  logic        i_cpol = 1'b0;
  logic        i_cpha = 1'b0;
  logic        i_sclk = 1'b0;
  logic        i_ss_n = 1'b1;
  wire         i_miso;
  logic        o_mosi;
  logic        o_tx_ready;
  logic [15:0] o_rx_data;
  logic        o_rx_valid;
  logic        o_tx_underrun;
  logic        o_rx_abort;
  logic        o_busy;

  logic loop_en  = 1'b1;
  logic miso_drv = 1'b0;
  assign i_miso = loop_en ? o_mosi : miso_drv;

  spim_shifter #(.DATA_SIZE(16)) dut (
    .i_sys_clk    (i_sys_clk),
    .i_sys_rst_n  (i_sys_rst_n),
    .i_tx_data    (i_tx_data),
    .i_tx_load    (i_tx_load),
    .i_lsb_first  (i_lsb_first),
    .i_cpol       (i_cpol),
    .i_cpha       (i_cpha),
    .i_sclk       (i_sclk),
    .i_ss_n       (i_ss_n),
    .i_miso       (i_miso),
    .o_mosi       (o_mosi),
    .o_tx_ready   (o_tx_ready),
    .o_rx_data    (o_rx_data),
    .o_rx_valid   (o_rx_valid),
    .o_tx_underrun(o_tx_underrun),
    .o_rx_abort   (o_rx_abort),
    .o_busy       (o_busy)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model state.
  logic        m_full, m_prev_ss, m_prev_sclk, m_armed, m_in_frame;
  logic [15:0] m_held, m_sent, m_rxacc, m_rx_data;
  int          m_nsamp;
  logic        e_valid, e_underrun, e_abort, e_busy;
  logic        mosi_log [16];
  int          cnt_valid = 0, cnt_underrun = 0, cnt_abort = 0;

  // Per-cycle compare: check outputs (set by last cycle's inputs), then
  // advance the model with this cycle's inputs.
  initial begin : compare
    logic start, endv, lead, trail, samp, bexp;
    forever begin
      @(negedge i_sys_clk);
      if (!i_sys_rst_n) begin
        m_full = 0; m_held = '0; m_sent = '0; m_rxacc = '0; m_rx_data = '0;
        m_prev_ss = 1; m_prev_sclk = 1; m_armed = 0; m_in_frame = 0; m_nsamp = 0;
        e_valid = 0; e_underrun = 0; e_abort = 0; e_busy = 0;
      end
      chk("rx_data",  32'(o_rx_data),     32'(m_rx_data));
      chk("rx_valid", 32'(o_rx_valid),    32'(e_valid));
      chk("underrun", 32'(o_tx_underrun), 32'(e_underrun));
      chk("rx_abort", 32'(o_rx_abort),    32'(e_abort));
      chk("busy",     32'(o_busy),        32'(e_busy));
      chk("tx_ready", 32'(o_tx_ready),    32'(!m_full));
      if (!e_busy) chk("mosi_idle", 32'(o_mosi), 32'd0);
      if (o_rx_valid)    cnt_valid++;
      if (o_tx_underrun) cnt_underrun++;
      if (o_rx_abort)    cnt_abort++;
      if (i_sys_rst_n) begin
        start = m_prev_ss && !i_ss_n && m_armed;
        endv  = !m_prev_ss && i_ss_n;
        lead  = (i_sclk != i_cpol) && (m_prev_sclk == i_cpol);
        trail = (i_sclk == i_cpol) && (m_prev_sclk != i_cpol);
        samp  = i_cpha ? trail : lead;
        e_valid = 0; e_underrun = 0; e_abort = 0;
        if (m_in_frame) begin
          if (endv) begin
            if (m_nsamp < 16) e_abort = 1;
            m_in_frame = 0;
          end else if (samp && m_nsamp < 16) begin
            bexp = i_lsb_first ? m_sent[m_nsamp] : m_sent[15 - m_nsamp];
            chk("mosi_bit", 32'(o_mosi), 32'(bexp));
            mosi_log[m_nsamp] = o_mosi;
            if (i_lsb_first) m_rxacc[m_nsamp] = i_miso;
            else             m_rxacc[15 - m_nsamp] = i_miso;
            m_nsamp++;
            if (m_nsamp == 16) begin
              m_rx_data = m_rxacc;
              e_valid = 1;
            end
          end
        end
        if (start && !m_in_frame) begin
          if (m_full) begin
            m_sent = m_held;
            m_full = 0;
          end else if (i_tx_load) begin
            m_sent = i_tx_data;
          end else begin
            m_sent = '0;
            e_underrun = 1;
          end
          m_in_frame = 1;
          m_nsamp = 0;
        end else if (i_tx_load && !m_full) begin
          m_held = i_tx_data;
          m_full = 1;
        end
        e_busy = m_in_frame;
        m_prev_ss = i_ss_n;
        m_prev_sclk = i_sclk;
        m_armed = m_armed | i_ss_n;
      end
    end
  end

  // Inputs change 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge i_sys_clk);
    #2;
  endtask

  task automatic cfg(input logic cpol, input logic cpha, input logic lsb);
    tick(1);
    i_cpol = cpol; i_cpha = cpha; i_lsb_first = lsb; i_sclk = cpol;
    tick(4);
  endtask

  task automatic load(input logic [15:0] d);
    tick(1);
    i_tx_load = 1; i_tx_data = d;
    tick(1);
    i_tx_load = 0;
  endtask

  int   frame_no = 0;
  logic ready_after_start;

  // One generator frame of ncyc SCLK periods (8 system clocks each).
  task automatic run_frame(input int ncyc, input logic load_at_start, input logic [15:0] d);
    tick(1);
    i_ss_n = 0;
    if (load_at_start) begin
      i_tx_load = 1; i_tx_data = d;
    end
    tick(1);
    i_tx_load = 0;
    ready_after_start = o_tx_ready;
    tick(3);
    for (int i = 0; i < ncyc; i++) begin
      i_sclk = ~i_cpol; tick(4);
      i_sclk = i_cpol;  tick(4);
    end
    i_ss_n = 1;
    tick(6);
    frame_no++;
    $display("frame %0d: cpol=%0d cpha=%0d lsb=%0d cycles=%0d rx_data=%h",
             frame_no, i_cpol, i_cpha, i_lsb_first, ncyc, o_rx_data);
  endtask

  function automatic logic [15:0] log_word_msb();
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15 - i] = mosi_log[i];
    return w;
  endfunction

  initial begin : main
    int v0, u0, a0;
    tick(3);
    chk("reset_ready", 32'(o_tx_ready), 32'd1);
    chk("reset_rx",    32'(o_rx_data),  32'd0);
    chk("reset_mosi",  32'(o_mosi),     32'd0);
    chk("reset_busy",  32'(o_busy),     32'd0);
    i_sys_rst_n = 1;

    // Mode 0, MSB first, loopback.
    cfg(0, 0, 0); loop_en = 1;
    load(16'hA5C3);
    v0 = cnt_valid;
    run_frame(16, 0, '0);
    chk("t1_rx", 32'(o_rx_data), 32'h0000A5C3);
    chk("t1_mosi_seq", 32'(log_word_msb()), 32'h0000A5C3);
    chk("t1_valid_cnt", 32'(cnt_valid - v0), 32'd1);

    // Mode 3, LSB first, MISO tied high.
    cfg(1, 1, 1); loop_en = 0; miso_drv = 1;
    load(16'h8001);
    run_frame(16, 0, '0);
    chk("t2_rx", 32'(o_rx_data), 32'h0000FFFF);
    chk("t2_first_bit", 32'(mosi_log[0]), 32'd1);
    chk("t2_ready_after_start", 32'(ready_after_start), 32'd1);

    // Start with nothing loaded.
    cfg(0, 0, 0); loop_en = 1;
    u0 = cnt_underrun; v0 = cnt_valid;
    run_frame(16, 0, '0);
    chk("t3_underrun_cnt", 32'(cnt_underrun - u0), 32'd1);
    chk("t3_rx", 32'(o_rx_data), 32'd0);
    chk("t3_valid_cnt", 32'(cnt_valid - v0), 32'd1);

    // Second load while full is dropped.
    cfg(0, 1, 0);
    load(16'h1234);
    load(16'hFFFF);
    chk("t4_ready_full", 32'(o_tx_ready), 32'd0);
    run_frame(16, 0, '0);
    chk("t4_rx", 32'(o_rx_data), 32'h00001234);
    chk("t4_ready_after", 32'(o_tx_ready), 32'd1);

    // Load in the start cycle with an empty holding register.
    cfg(1, 0, 1);
    u0 = cnt_underrun;
    run_frame(16, 1, 16'h5A5A);
    chk("t5_rx", 32'(o_rx_data), 32'h00005A5A);
    chk("t5_no_underrun", 32'(cnt_underrun - u0), 32'd0);
    chk("t5_ready_after_start", 32'(ready_after_start), 32'd1);

    // Premature end after 7 sample edges.
    cfg(0, 0, 0);
    load(16'h0F0F);
    a0 = cnt_abort; v0 = cnt_valid;
    run_frame(7, 0, '0);
    chk("t6_abort_cnt", 32'(cnt_abort - a0), 32'd1);
    chk("t6_rx_kept", 32'(o_rx_data), 32'h00005A5A);
    chk("t6_no_valid", 32'(cnt_valid - v0), 32'd0);
    chk("t6_idle", 32'(o_busy), 32'd0);

    // Reset in the middle of a frame, then a clean frame.
    cfg(0, 1, 1);
    load(16'hC0DE);
    a0 = cnt_abort;
    tick(1); i_ss_n = 0; tick(4);
    for (int i = 0; i < 5; i++) begin
      i_sclk = 1; tick(4); i_sclk = 0; tick(4);
    end
    i_sys_rst_n = 0;
    tick(3);
    i_sys_rst_n = 1;
    tick(1);
    chk("t7_rst_rx",    32'(o_rx_data),  32'd0);
    chk("t7_rst_ready", 32'(o_tx_ready), 32'd1);
    chk("t7_rst_busy",  32'(o_busy),     32'd0);
    chk("t7_rst_mosi",  32'(o_mosi),     32'd0);
    for (int i = 0; i < 3; i++) begin
      i_sclk = 1; tick(4); i_sclk = 0; tick(4);
    end
    chk("t7_ignored_busy", 32'(o_busy), 32'd0);
    i_ss_n = 1; tick(6);
    chk("t7_no_abort", 32'(cnt_abort - a0), 32'd0);
    load(16'h3C96);
    v0 = cnt_valid;
    run_frame(16, 0, '0);
    chk("t7_rx", 32'(o_rx_data), 32'h00003C96);
    chk("t7_valid_cnt", 32'(cnt_valid - v0), 32'd1);

    tick(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spim_shifter.md
# spim_shifter

Data path stage directly downstream of the SPI master clock/slave-select generator. It consumes that generator's registered SCLK and active-low slave-select outputs and drives MOSI from a single-entry transmit holding register. It also captures MISO into a receive word, supporting all four CPOL/CPHA modes with MSB- or LSB-first ordering. Everything runs in the system clock domain; SCLK is treated as a data signal and its edges are detected by sampling.

## Interface
- DATA_SIZE, 16, bits per transfer; must equal the generator's DATA_SIZE.

- i_sys_clk  in  1  system clock; all flops on rising edge.
- i_sys_rst_n  in  1  reset, asynchronous assert, active-low.
- i_tx_data  in  DATA_SIZE  word to transmit.
- i_tx_load  in  1  one-cycle strobe that writes i_tx_data into the holding register.
- i_lsb_first  in  1  0 = MSB first, 1 = LSB first; applies to both TX and RX.
- i_cpol  in  1  idle SCLK level; same value the generator receives.
- i_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- i_sclk  in  1  SCLK from the generator.
- i_ss_n  in  1  slave select from the generator, active-low.
- i_miso  in  1  slave data; no synchroniser inside this block.
- o_mosi  out  1  master data.
- o_tx_ready  out  1  holding register empty; i_tx_load is accepted only while this is high.
- o_rx_data  out  DATA_SIZE  last complete received word; held until the next complete word.
- o_rx_valid  out  1  one-cycle pulse when o_rx_data updates.
- o_tx_underrun  out  1  one-cycle pulse when a transfer starts with an empty holding register.
- o_rx_abort  out  1  one-cycle pulse when i_ss_n rises before DATA_SIZE bits are sampled.
- o_busy  out  1  high in XFER and DONE.

## Operation
- Edge detection:
  - sclk_d and ss_d are registered copies of i_sclk and i_ss_n; both reset to 1.
  - A leading edge is i_sclk != i_cpol while sclk_d == i_cpol.
  - A trailing edge is the reverse transition.
  - A start is ss_d=1 with i_ss_n=0. An end is ss_d=0 with i_ss_n=1.
- Sample edge is the leading edge when i_cpha=0 and the trailing edge when i_cpha=1. The other edge type is the shift edge.
- Holding register:
  - i_tx_load with o_tx_ready=1 captures i_tx_data and clears o_tx_ready.
  - i_tx_load with o_tx_ready=0 is ignored; held data is not overwritten.
- States (one-hot): IDLE, XFER, DONE.
- IDLE:
  - o_mosi = 0.
  - On start, the shift register loads the holding register and o_tx_ready is set. The bit counter clears and the state goes to XFER.
  - If o_tx_ready=1 and i_tx_load=1 in the start cycle, i_tx_data is loaded directly into the shift register and o_tx_ready stays 1.
  - If o_tx_ready=1 and i_tx_load=0 in the start cycle, zeros are loaded and o_tx_underrun pulses.
- XFER, i_cpha=0:
  - o_mosi shows bit 0 from the cycle after start.
  - Advances to bit k+1 on the k-th trailing edge (k counted from 0).
- XFER, i_cpha=1:
  - o_mosi holds bit 0 until the first leading edge.
  - Shows bit k from the (k+1)-th leading edge onward.
- Bit order: bit 0 is bit DATA_SIZE-1 of the word when i_lsb_first=0, and bit 0 of the word when i_lsb_first=1.
- Receive:
  - Each sample edge shifts i_miso into the receive register, following i_lsb_first, and increments the bit counter (width clog2(DATA_SIZE+1)).
  - When the counter reaches DATA_SIZE, the word goes to o_rx_data, o_rx_valid pulses, and the state goes to DONE.
  - Sample and shift edges after the counter reaches DATA_SIZE are ignored.
- DONE: o_mosi holds its last value. On end, the state goes to IDLE.
- End in XFER (premature end): o_rx_abort pulses, o_rx_data is unchanged, the state goes to IDLE. The holding register is unaffected.
- i_cpol, i_cpha and i_lsb_first must be static while i_ss_n=0. Behaviour is undefined otherwise.
- Reset values:
  - o_mosi=0, o_tx_ready=1, o_rx_data=0.
  - o_rx_valid, o_tx_underrun, o_rx_abort and o_busy = 0.
  - Holding, shift and receive registers 0; state IDLE.
- Reset assertion mid-transfer aborts immediately with no o_rx_abort pulse. The block ignores the remainder of the frame until the next start after i_ss_n has been seen high.

## Timing
- Edge and start conditions are combinational in cycle n, the first cycle the new i_sclk or i_ss_n level is present. All resulting register updates appear in cycle n+1.
- i_miso is captured at the end of cycle n of each sample edge. Any external pad synchroniser latency must be covered by the generator's clock-period and setup settings.
- o_mosi changes in cycle n+1 after a shift edge, at least half an SCLK period before the next sample edge for any generator clock period ≥ 4.
- o_rx_valid is high in cycle n+1 after the DATA_SIZE-th sample edge, for exactly one cycle.
- o_tx_ready rises in cycle n+1 after start. A new i_tx_load is accepted from that cycle.

## Test plan
- CPOL=0, CPHA=0, MSB first, load 16'hA5C3, i_miso looped from o_mosi, generator period 8: o_mosi shows 1,0,1,0,0,1,0,1,… in order; o_rx_data=16'hA5C3; exactly one o_rx_valid.
- CPOL=1, CPHA=1, LSB first, load 16'h8001, i_miso tied 1: o_mosi shows bit 0=1 first; o_rx_data=16'hFFFF; o_tx_ready=1 after start.
- Start with no load: o_tx_underrun pulses once; o_mosi stays 0 for all 16 bits; the transfer completes.
- Load 16'h1234, then a second load 16'hFFFF before start: the transfer sends 16'h1234; the second load is ignored.
- i_tx_load=16'h5A5A in the same cycle as start with an empty holding register: 16'h5A5A is sent; no underrun; o_tx_ready stays 1.
- Force i_ss_n high after 7 sample edges: o_rx_abort pulses, o_rx_data is unchanged, state returns to IDLE. Separately, assert i_sys_rst_n mid-transfer: all outputs return to reset values, and the next full frame receives correctly.
